// File: rtl/axi_ram_cmd_mem_if.sv
// RAM command/response bundle between the AXI RAM front end and the RAM responder.
// master = command source / response sink, slave = RAM responder.
interface axi_ram_cmd_mem_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    parameter int AUSER_WIDTH = 1,
    parameter int WUSER_WIDTH = 1,
    parameter int RUSER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]    ram_cmd_id;
    logic [ADDR_WIDTH-1:0]  ram_cmd_addr;
    logic                   ram_cmd_lock;
    logic [3:0]             ram_cmd_cache;
    logic [2:0]             ram_cmd_prot;
    logic [3:0]             ram_cmd_qos;
    logic [3:0]             ram_cmd_region;
    logic [AUSER_WIDTH-1:0] ram_cmd_auser;
    logic [DATA_WIDTH-1:0]  ram_cmd_wr_data;
    logic [STRB_WIDTH-1:0]  ram_cmd_wr_strb;
    logic [WUSER_WIDTH-1:0] ram_cmd_wr_user;
    logic                   ram_cmd_wr_en;
    logic                   ram_cmd_rd_en;
    logic                   ram_cmd_last;
    logic                   ram_cmd_ready;

    logic [ID_WIDTH-1:0]    ram_rd_resp_id;
    logic [DATA_WIDTH-1:0]  ram_rd_resp_data;
    logic                   ram_rd_resp_last;
    logic [RUSER_WIDTH-1:0] ram_rd_resp_user;
    logic                   ram_rd_resp_valid;
    logic                   ram_rd_resp_ready;

    modport master (
        output ram_cmd_id, ram_cmd_addr, ram_cmd_lock, ram_cmd_cache,
        output ram_cmd_prot, ram_cmd_qos, ram_cmd_region, ram_cmd_auser,
        output ram_cmd_wr_data, ram_cmd_wr_strb, ram_cmd_wr_user,
        output ram_cmd_wr_en, ram_cmd_rd_en, ram_cmd_last,
        input  ram_cmd_ready,
        input  ram_rd_resp_id, ram_rd_resp_data, ram_rd_resp_last,
        input  ram_rd_resp_user, ram_rd_resp_valid,
        output ram_rd_resp_ready
    );

    modport slave (
        input  ram_cmd_id, ram_cmd_addr, ram_cmd_lock, ram_cmd_cache,
        input  ram_cmd_prot, ram_cmd_qos, ram_cmd_region, ram_cmd_auser,
        input  ram_cmd_wr_data, ram_cmd_wr_strb, ram_cmd_wr_user,
        input  ram_cmd_wr_en, ram_cmd_rd_en, ram_cmd_last,
        output ram_cmd_ready,
        output ram_rd_resp_id, ram_rd_resp_data, ram_rd_resp_last,
        output ram_rd_resp_user, ram_rd_resp_valid,
        input  ram_rd_resp_ready
    );
endinterface

// File: rtl/axi_ram_cmd_mem.sv
// RAM responder: byte-strobed memory behind the unified RAM command port.
// Reads go through a 1-deep pipeline into a response FIFO bounded by an outstanding count.
module axi_ram_cmd_mem #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int ID_WIDTH       = 8,
    parameter int AUSER_WIDTH    = 1,
    parameter int WUSER_WIDTH    = 1,
    parameter int RUSER_WIDTH    = 1,
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    axi_ram_cmd_mem_if.slave s_ram
);
    localparam int LSB       = $clog2(STRB_WIDTH);
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = $clog2(FIFO_DEPTH + 1);
    localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam int SW        = ADDR_WIDTH + MEM_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]     r_mem [MEM_DEPTH];

    logic                      r_p_valid;
    logic [DATA_WIDTH-1:0]     r_p_data;
    logic [ID_WIDTH-1:0]       r_p_id;
    logic                      r_p_last;

    logic [DATA_WIDTH-1:0]     r_fifo_data [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]       r_fifo_id   [FIFO_DEPTH];
    logic                      r_fifo_last [FIFO_DEPTH];
    logic [PW:0]               r_wr_ptr;
    logic [PW:0]               r_rd_ptr;
    logic [CW-1:0]             r_outstanding;

    logic                      w_ready;
    logic                      w_wr_acc;
    logic                      w_rd_acc;
    logic                      w_valid;
    logic                      w_pop;
    logic [SW-1:0]             w_shift;
    logic [MEM_ADDR_WIDTH-1:0] w_idx;
    logic [PW-1:0]             w_wr_slot;
    logic [PW-1:0]             w_rd_slot;
    logic [AUSER_WIDTH-1:0]    w_auser;
    logic [WUSER_WIDTH-1:0]    w_wuser;
    logic                      w_unused;

    // The outstanding limit spans pipeline and FIFO, so the FIFO cannot overflow.
    assign w_ready  = !rst && (r_outstanding < CW'(FIFO_DEPTH));
    // A command with both enables is treated as a write only.
    assign w_wr_acc = s_ram.ram_cmd_wr_en && w_ready;
    assign w_rd_acc = s_ram.ram_cmd_rd_en && !s_ram.ram_cmd_wr_en && w_ready;

    // Word index: drop lane bits, keep the low MEM_ADDR_WIDTH bits (higher bits alias).
    assign w_shift = {{MEM_ADDR_WIDTH{1'b0}}, s_ram.ram_cmd_addr} >> LSB;
    assign w_idx   = w_shift[MEM_ADDR_WIDTH-1:0];

    assign w_wr_slot = r_wr_ptr[PW-1:0];
    assign w_rd_slot = r_rd_ptr[PW-1:0];
    assign w_valid   = (r_wr_ptr != r_rd_ptr);
    assign w_pop     = w_valid && s_ram.ram_rd_resp_ready;

    assign s_ram.ram_cmd_ready     = w_ready;
    assign s_ram.ram_rd_resp_valid = w_valid;
    assign s_ram.ram_rd_resp_data  = r_fifo_data[w_rd_slot];
    assign s_ram.ram_rd_resp_id    = r_fifo_id[w_rd_slot];
    assign s_ram.ram_rd_resp_last  = r_fifo_last[w_rd_slot];
    assign s_ram.ram_rd_resp_user  = {RUSER_WIDTH{1'b0}};

    assign w_auser  = s_ram.ram_cmd_auser;
    assign w_wuser  = s_ram.ram_cmd_wr_user;
    assign w_unused = ^{w_auser, w_wuser, w_shift, s_ram.ram_cmd_addr,
                        s_ram.ram_cmd_lock, s_ram.ram_cmd_cache,
                        s_ram.ram_cmd_prot, s_ram.ram_cmd_qos,
                        s_ram.ram_cmd_region};

    // Byte-lane write port and registered read capture; memory survives reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_ram.ram_cmd_wr_strb[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= s_ram.ram_cmd_wr_data[i*8 +: 8];
                end
            end
        end
        if (w_rd_acc) begin
            r_p_data <= r_mem[w_idx];
            r_p_id   <= s_ram.ram_cmd_id;
            r_p_last <= s_ram.ram_cmd_last;
        end
    end

    // Read pipeline valid, FIFO pointers and outstanding-read count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_valid     <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
        end else begin
            r_p_valid <= w_rd_acc;
            if (r_p_valid) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_rd_acc, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Response FIFO storage; cleared so the idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_id[i]   <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else if (r_p_valid) begin
            r_fifo_data[w_wr_slot] <= r_p_data;
            r_fifo_id[w_wr_slot]   <= r_p_id;
            r_fifo_last[w_wr_slot] <= r_p_last;
        end
    end
endmodule
